// File: rtl/sr_flag_arbiter_if.sv
// Requester-side bundle for sr_flag_arbiter: per-requester set/clear commands in,
// one-hot grant plus the shared SR flag bank out.
interface sr_flag_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_FLAGS = 8
);
    localparam int IDX_W = ($clog2(NUM_FLAGS) > 1) ? $clog2(NUM_FLAGS) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_set;
    logic [NUM_REQ-1:0]       req_clr;
    logic [NUM_REQ*IDX_W-1:0] req_idx;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ-1:0]       gnt;
    logic                     err;
    logic [NUM_FLAGS-1:0]     flag_q;
    logic [NUM_FLAGS-1:0]     flag_q_bar;
    logic                     busy;

    modport slave (
        input  req, req_set, req_clr, req_idx, req_lock,
        output gnt, err, flag_q, flag_q_bar, busy
    );

    modport master (
        output req, req_set, req_clr, req_idx, req_lock,
        input  gnt, err, flag_q, flag_q_bar, busy
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter applying set/clear commands to a shared SR flag bank.
// Optional SR_ARB_LOCK_EN lets a winner hold the bank for back-to-back commands.
module sr_flag_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_FLAGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    sr_flag_arbiter_if.slave  bus
);
    localparam int IDX_W = ($clog2(NUM_FLAGS) > 1) ? $clog2(NUM_FLAGS) : 1;
    localparam int PTR_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

`ifdef SR_ARB_LOCK_EN
    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_LOCKED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_APPLY} state_t;
`endif

    state_t               r_state, w_next;
    logic [PTR_W-1:0]     r_rr_ptr, r_win;
    logic                 r_set, r_clr;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_FLAGS-1:0] r_q, r_qb;

    logic                 w_found;
    logic [PTR_W-1:0]     w_pick;
    logic                 w_cap;
    logic [PTR_W-1:0]     w_cap_win;
    logic                 w_adv;
    logic [NUM_REQ-1:0]   w_gnt;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requesting index at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_found && bus.req[j]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_cap     = 1'b0;
        w_cap_win = w_pick;
        w_adv     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_cap  = 1'b1;
                    w_next = S_APPLY;
                end
            end
            S_APPLY: begin
                w_adv  = 1'b1;
                w_next = S_IDLE;
`ifdef SR_ARB_LOCK_EN
                if (bus.req_lock[r_win]) begin
                    w_adv  = 1'b0;
                    w_next = S_LOCKED;
                end
`endif
            end
`ifdef SR_ARB_LOCK_EN
            // Only the owner is served; pointer moves past it once it lets go.
            S_LOCKED: begin
                if (bus.req[r_win]) begin
                    w_cap     = 1'b1;
                    w_cap_win = r_win;
                    w_next    = S_APPLY;
                end else if (!bus.req_lock[r_win]) begin
                    w_adv  = 1'b1;
                    w_next = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

`ifndef SR_ARB_LOCK_EN
    logic w_lock_unused;
    assign w_lock_unused = ^bus.req_lock;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_set    <= 1'b0;
            r_clr    <= 1'b0;
            r_idx    <= '0;
            r_q      <= '0;
            r_qb     <= '0;
        end else begin
            if (w_cap) begin
                r_win <= w_cap_win;
                r_set <= bus.req_set[w_cap_win];
                r_clr <= bus.req_clr[w_cap_win];
                r_idx <= bus.req_idx[w_cap_win*IDX_W +: IDX_W];
            end
            if (w_adv) r_rr_ptr <= f_inc(r_win);
            // Set dominates clear; an out-of-range index matches no flag.
            if (r_state == S_APPLY) begin
                for (int i = 0; i < NUM_FLAGS; i++) begin
                    if (32'(r_idx) == i) begin
                        if (r_set) begin
                            r_q[i]  <= 1'b1;
                            r_qb[i] <= 1'b0;
                        end else if (r_clr) begin
                            r_q[i]  <= 1'b0;
                            r_qb[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (r_state == S_APPLY) w_gnt[r_win] = 1'b1;
    end

    assign bus.gnt        = w_gnt;
    assign bus.err        = (r_state == S_APPLY) && (32'(r_idx) >= NUM_FLAGS);
    assign bus.flag_q     = r_q;
    assign bus.flag_q_bar = r_qb;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model of round-robin order and SR flag rules.
module tb_sr_flag_arbiter;
    localparam int NR = 4;
    localparam int NF = 6;   // non power of 2 so out-of-range indices are encodable
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NUM_REQ(NR), .NUM_FLAGS(NF)) bus ();
    sr_flag_arbiter #(.NUM_REQ(NR), .NUM_FLAGS(NF)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    logic [NF-1:0] m_q, m_qb;
    int m_rr;
    bit ap_v;
    int ap_w, ap_i;
    bit ap_s, ap_c;
    logic [NR-1:0] last_gnt;
    logic last_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int r, input bit v, input bit s, input bit c, input int i);
        bus.req[r]               = v;
        bus.req_set[r]           = s;
        bus.req_clr[r]           = c;
        bus.req_idx[r*IW +: IW]  = IW'(i);
    endtask

    task automatic model_reset();
        m_q = '0; m_qb = '0; m_rr = 0; ap_v = 1'b0;
        ap_w = 0; ap_i = 0; ap_s = 1'b0; ap_c = 1'b0;
    endtask

    // One clock: model decides/applies on the values driven now, then outputs are compared.
    task automatic step();
        bit nv;
        int nw;
        nv = 1'b0; nw = 0;
        if (ap_v) begin
            if (ap_i < NF) begin
                if (ap_s)      begin m_q[ap_i] = 1'b1; m_qb[ap_i] = 1'b0; end
                else if (ap_c) begin m_q[ap_i] = 1'b0; m_qb[ap_i] = 1'b1; end
            end
            m_rr = (ap_w + 1) % NR;
            ap_v = 1'b0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_rr + k) % NR;
                if (!nv && bus.req[j]) begin nv = 1'b1; nw = j; end
            end
            if (nv) begin
                ap_w = nw;
                ap_s = bus.req_set[nw];
                ap_c = bus.req_clr[nw];
                ap_i = int'(bus.req_idx[nw*IW +: IW]);
            end
            ap_v = nv;
        end
        @(posedge clk); #1;
        chk("gnt",     64'(bus.gnt),        ap_v ? (64'd1 << ap_w) : 64'd0);
        chk("err",     64'(bus.err),        64'(ap_v && ap_i >= NF));
        chk("busy",    64'(bus.busy),       64'(ap_v));
        chk("flag_q",  64'(bus.flag_q),     64'(m_q));
        chk("flag_qb", 64'(bus.flag_q_bar), 64'(m_qb));
    endtask

    task automatic cmd(input int r, input bit s, input bit c, input int i);
        drive(r, 1'b1, s, c, i);
        step();
        last_gnt = bus.gnt;
        last_err = bus.err;
        drive(r, 1'b0, 1'b0, 1'b0, 0);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [NF-1:0] snap;
        int lk[$];
        int exp_lk[4];
        int cnt0;
        bus.req = '0; bus.req_set = '0; bus.req_clr = '0; bus.req_idx = '0; bus.req_lock = '0;
        last_gnt = '0; last_err = 1'b0;
        do_reset();

        repeat (5) step();

        cmd(1, 1'b1, 1'b0, 3);
        chk("t_set_gnt", 64'(last_gnt), 64'h2);
        chk("t_set_q",   64'(bus.flag_q),     64'h08);
        chk("t_set_qb",  64'(bus.flag_q_bar), 64'h00);
        cmd(1, 1'b0, 1'b1, 3);
        chk("t_clr_q",   64'(bus.flag_q),     64'h00);
        chk("t_clr_qb",  64'(bus.flag_q_bar), 64'h08);

        cmd(2, 1'b1, 1'b1, 5);
        chk("t_both_gnt", 64'(last_gnt), 64'h4);
        chk("t_both_q5",  64'(bus.flag_q[5]),     64'd1);
        chk("t_both_qb5", 64'(bus.flag_q_bar[5]), 64'd0);
        snap = bus.flag_q;
        cmd(0, 1'b1, 1'b0, 7);
        chk("t_oor_err", 64'(last_err), 64'd1);
        chk("t_oor_q",   64'(bus.flag_q), 64'(snap));
        cmd(3, 1'b0, 1'b0, 0);
        chk("t_nop_err", 64'(last_err), 64'd0);

        do_reset();
        for (int r = 0; r < NR; r++) drive(r, 1'b1, 1'b1, 1'b0, r);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t_rr_gnt", 64'(bus.gnt), 64'd1 << (k % NR));
            step();
            if (k == 3) chk("t_rr_q", 64'(bus.flag_q), 64'h0F);
        end
        for (int r = 0; r < NR; r++) drive(r, 1'b0, 1'b0, 1'b0, 0);
        step();

        drive(3, 1'b1, 1'b1, 1'b0, 2);
        step();
        chk("t_rst_pre_gnt", 64'(bus.gnt), 64'h8);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t_rst_gnt",  64'(bus.gnt),        64'd0);
        chk("t_rst_busy", 64'(bus.busy),       64'd0);
        chk("t_rst_q",    64'(bus.flag_q),     64'd0);
        chk("t_rst_qb",   64'(bus.flag_q_bar), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        chk("t_rst_regnt", 64'(bus.gnt), 64'h8);
        drive(3, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("t_rst_q2", 64'(bus.flag_q), 64'h04);

        for (int n = 0; n < 400; n++) begin
            int gw;
            step();
            gw = ap_v ? ap_w : -1;
            for (int r = 0; r < NR; r++) begin
                if (r == gw) begin
                    if ($urandom_range(1) == 1)
                        drive(r, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(7));
                    else
                        drive(r, 1'b0, 1'b0, 1'b0, 0);
                end else if (!bus.req[r]) begin
                    if ($urandom_range(2) == 0)
                        drive(r, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(7));
                end else if ($urandom_range(15) == 0) begin
                    drive(r, 1'b0, 1'b0, 1'b0, 0);
                end
            end
`ifdef SR_ARB_LOCK_EN
            bus.req_lock = '0;
`else
            bus.req_lock = NR'($urandom_range((1 << NR) - 1));
`endif
        end
        bus.req = '0; bus.req_lock = '0;

        do_reset();
        cnt0 = 0;
        drive(0, 1'b1, 1'b1, 1'b0, 0);
        bus.req_lock[0] = 1'b1;
        drive(3, 1'b1, 1'b1, 1'b0, 3);
        for (int c = 0; c < 40 && lk.size() < 4; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < NR; r++) if (bus.gnt[r]) lk.push_back(r);
            if (bus.gnt[0]) begin
                cnt0++;
                if (cnt0 == 3) begin
                    drive(0, 1'b0, 1'b0, 1'b0, 0);
                    bus.req_lock[0] = 1'b0;
                end
            end
        end
`ifdef SR_ARB_LOCK_EN
        exp_lk = '{0, 0, 0, 3};
`else
        exp_lk = '{0, 3, 0, 3};
`endif
        chk("t_lock_cnt", 64'(lk.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk("t_lock_order", 64'((k < lk.size()) ? lk[k] : -1), 64'(exp_lk[k]));
        bus.req = '0; bus.req_lock = '0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
